// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in / serial-out serializer.
package piso_pkg;

  // Two-state control: nothing held, or a word being shifted out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits needed by the position counter; guarded so the bad-WIDTH path
  // still elaborates far enough to report a readable error.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready handshakes on both sides.
// The first bit of a word is presented on dout directly from the load, so the
// shift register only needs to hold the remaining WIDTH-1 bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  output logic             dout,
  output logic             dout_valid,
  input  logic             s_ready,
  output logic             last
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  // Refuse to build a serializer narrower than two bits.
  generate
    if (WIDTH < 2) begin : g_width_check
      $error("piso_serializer: WIDTH must be at least 2");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             word_xfer;
  logic             bit_xfer;

  // A new word may enter when idle, or when the final bit leaves this cycle.
  // Held low during reset so no word is accepted while rst is asserted.
  assign load_ready = !rst && ((state_q == IDLE) || (last_q && s_ready));
  assign word_xfer  = load_valid && load_ready;
  assign bit_xfer   = valid_q && s_ready;

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign last       = last_q;

  // Next-state logic: a load wins over the last-bit retire so back-to-back
  // words stream with no idle gap.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (word_xfer) begin
      state_d = SHIFT;
      valid_d = 1'b1;
      cnt_d   = '0;
      last_d  = 1'b0;
      if (MSB_FIRST != 0) begin
        dout_d  = d[WIDTH-1];
        shreg_d = d << 1;
      end else begin
        dout_d  = d[0];
        shreg_d = d >> 1;
      end
    end else if (bit_xfer) begin
      if (last_q) begin
        state_d = IDLE;
        valid_d = 1'b0;
        dout_d  = 1'b0;
        last_d  = 1'b0;
        cnt_d   = '0;
        shreg_d = '0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        last_d = ((cnt_q + 1'b1) == CNT_LAST);
        if (MSB_FIRST != 0) begin
          dout_d  = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
        end else begin
          dout_d  = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
    end
  end

  // State and output registers; reset drops any partially sent word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (4-bit MSB-first, 4-bit
// LSB-first, 8-bit MSB-first). Stimulus pushes hand-written expected bit
// streams; a negedge monitor pops and compares on every accepted bit.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       lv_a = 1'b0, lv_b = 1'b0, lv_c = 1'b0;
  logic       sr_a = 1'b1, sr_b = 1'b1, sr_c = 1'b1;
  logic [3:0] d_a = '0, d_b = '0;
  logic [7:0] d_c = '0;
  logic       lr_a, lr_b, lr_c;
  logic       do_a, do_b, do_c;
  logic       dv_a, dv_b, dv_c;
  logic       la_a, la_b, la_c;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .load_valid(lv_a), .load_ready(lr_a), .d(d_a),
    .dout(do_a), .dout_valid(dv_a), .s_ready(sr_a), .last(la_a));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .load_valid(lv_b), .load_ready(lr_b), .d(d_b),
    .dout(do_b), .dout_valid(dv_b), .s_ready(sr_b), .last(la_b));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .load_valid(lv_c), .load_ready(lr_c), .d(d_c),
    .dout(do_c), .dout_valid(dv_c), .s_ready(sr_c), .last(la_c));

  int vectors = 0;
  int miscompares = 0;

  // Expected entries are {bit, last}.
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] qc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h at %0t", name, act, $time);
    end
  endtask

  // Push the first n bits of stream s (s[n-1] leaves first); fin flags the
  // final one as last.
  task automatic push(input int k, input logic [7:0] s, input int n, input bit fin);
    for (int i = 0; i < n; i++) begin
      logic [1:0] e;
      e = {s[n-1-i], (fin && (i == n - 1))};
      case (k)
        0: qa.push_back(e);
        1: qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted serial bit is checked against the scoreboard.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst) begin
      if (dv_a && sr_a) begin
        if (qa.size() == 0) chk("a_unexpected_bit", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_bit", 32'(do_a), 32'(e[1]));
          chk("a_last", 32'(la_a), 32'(e[0]));
        end
      end
      if (dv_b && sr_b) begin
        if (qb.size() == 0) chk("b_unexpected_bit", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_bit", 32'(do_b), 32'(e[1]));
          chk("b_last", 32'(la_b), 32'(e[0]));
        end
      end
      if (dv_c && sr_c) begin
        if (qc.size() == 0) chk("c_unexpected_bit", 1, 0);
        else begin
          e = qc.pop_front();
          chk("c_bit", 32'(do_c), 32'(e[1]));
          chk("c_last", 32'(la_c), 32'(e[0]));
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_a_outs", {dv_a, do_a, la_a, lr_a}, 4'b0000);
    chk("rst_b_outs", {dv_b, do_b, la_b, lr_b}, 4'b0000);
    chk("rst_c_outs", {dv_c, do_c, la_c, lr_c}, 4'b0000);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("a_ready_idle", 32'(lr_a), 1);

    // 4-bit MSB-first, 1010 -> 1,0,1,0; load on first edge after reset release
    lv_a = 1'b1; d_a = 4'b1010; push(0, 8'b1010, 4, 1);
    tick();
    lv_a = 1'b0;
    chk("a_first_bit_latency", {dv_a, do_a, la_a}, 3'b110);
    repeat (4) tick();
    chk("a_idle_after", {dv_a, do_a, la_a}, 3'b000);

    // 4-bit LSB-first, 1010 -> 0,1,0,1
    lv_b = 1'b1; d_b = 4'b1010; push(1, 8'b0101, 4, 1);
    tick();
    lv_b = 1'b0;
    repeat (4) tick();
    chk("b_idle_after", {dv_b, do_b, la_b}, 3'b000);

    // Back-to-back: 1010 then 0101 with load_valid held
    lv_a = 1'b1; d_a = 4'b1010; push(0, 8'b1010, 4, 1);
    tick();
    d_a = 4'b0101; push(0, 8'b0101, 4, 1);
    for (int i = 0; i < 4; i++) begin
      chk("a_b2b_ready", 32'(lr_a), (i == 3) ? 1 : 0);
      chk("a_b2b_valid", 32'(dv_a), 1);
      tick();
    end
    lv_a = 1'b0;
    chk("a_b2b_no_gap", {dv_a, do_a, la_a}, 3'b100);
    repeat (4) tick();
    chk("a_b2b_idle_after", 32'(dv_a), 0);

    // Stall: 1100 with s_ready low two cycles after the first bit; d toggled
    lv_a = 1'b1; d_a = 4'b1100; push(0, 8'b1100, 4, 1);
    tick();
    lv_a = 1'b0; d_a = 4'b0000; sr_a = 1'b0;
    chk("a_stall_hold0", {dv_a, do_a, la_a, lr_a}, 4'b1100);
    tick();
    chk("a_stall_hold1", {dv_a, do_a, la_a, lr_a}, 4'b1100);
    tick();
    chk("a_stall_hold2", {dv_a, do_a, la_a}, 3'b110);
    sr_a = 1'b1;
    repeat (4) tick();
    chk("a_stall_idle_after", 32'(dv_a), 0);

    // 8-bit: A5 interrupted by reset after three bits, then 3C
    lv_c = 1'b1; d_c = 8'hA5; push(2, 8'b00000101, 3, 0);
    tick();
    lv_c = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("c_rst_midword", {dv_c, do_c, la_c, lr_c}, 4'b0000);
    @(posedge clk);
    #1;
    chk("c_rst_held", {dv_c, do_c, la_c}, 3'b000);
    rst = 1'b0;
    #1;
    chk("c_ready_after_rst", 32'(lr_c), 1);
    lv_c = 1'b1; d_c = 8'h3C; push(2, 8'b00111100, 8, 1);
    tick();
    lv_c = 1'b0;
    repeat (8) tick();
    chk("c_idle_after", {dv_c, do_c, la_c}, 3'b000);

    // All expected bits must have been delivered
    tick();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qc_drained", qc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range WIDTH >= 2.
REQ-002 Parameter MSB_FIRST, default 1, bit order: 1 = d[WIDTH-1] first, 0 = d[0] first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load_valid  input  1  parallel word on d is offered.
REQ-006 load_ready  output  1  block accepts a word this cycle.
REQ-007 d  input  WIDTH  parallel data word.
REQ-008 dout  output  1  current serial bit, registered.
REQ-009 dout_valid  output  1  dout holds a valid bit.
REQ-010 s_ready  input  1  serial consumer accepts dout this cycle.
REQ-011 last  output  1  dout is the final bit of the current word.

Function
REQ-012 Word transfer occurs on a rising edge with load_valid && load_ready; d is captured into an internal WIDTH-bit shift register.
REQ-013 Bit transfer occurs on a rising edge with dout_valid && s_ready.
REQ-014 FSM states: IDLE (no word held) and SHIFT (word held, dout_valid = 1).
REQ-015 IDLE -> SHIFT on word transfer; SHIFT -> IDLE on transfer of the bit with last = 1 and no simultaneous word transfer; SHIFT -> SHIFT otherwise.
REQ-016 Latency: the first bit of a word appears on dout with dout_valid = 1 in the cycle after the word-transfer edge.
REQ-017 Each bit transfer advances dout to the next bit in MSB_FIRST order; a bit counter of $clog2(WIDTH) bits tracks position.
REQ-018 When s_ready = 0 in SHIFT, dout, last, dout_valid and the counter hold unchanged.
REQ-019 last = 1 exactly while the WIDTH-th bit of a word is on dout.
REQ-020 load_ready = 1 in IDLE, and in SHIFT only when last && s_ready (combinational path from s_ready permitted); 0 otherwise.
REQ-021 Back-to-back: word transfer simultaneous with last-bit transfer loads the new word; its first bit appears next cycle with no idle gap.
REQ-022 d and load_valid are ignored while load_ready = 0; changes on d during SHIFT do not affect the output stream.
REQ-023 In IDLE, dout = 0 and last = 0.

Reset
REQ-024 While rst = 1: state = IDLE, shift register = 0, counter = 0, dout = 0, dout_valid = 0, last = 0, load_ready = 0.
REQ-025 Reset asserted mid-word discards the remaining bits immediately; no partial word resumes after release.
REQ-026 First word transfer possible on the first rising edge after rst deasserts.

Structure
REQ-027 Package piso_pkg holds the FSM state typedef (IDLE, SHIFT) and the counter-width function/constant derived from WIDTH.
REQ-028 Single module; no sub-module required.
REQ-029 Elaboration fails for WIDTH < 2.

Verification
REQ-030 WIDTH=4, MSB_FIRST=1, s_ready=1, load 4'b1010 -> dout 1,0,1,0 on four consecutive cycles, last=1 on 4th only, dout_valid low after.
REQ-031 WIDTH=4, MSB_FIRST=0, load 4'b1010 -> dout 0,1,0,1, last on 4th bit.
REQ-032 WIDTH=4, MSB_FIRST=1, load_valid held with 4'b1010 then 4'b0101 -> 8 contiguous valid bits 1,0,1,0,0,1,0,1, load_ready pulses with the 4th bit.
REQ-033 WIDTH=4, load 4'b1100, s_ready=0 for two cycles after first bit -> dout holds 1 with dout_valid=1, then 1,0,0 resume; d toggled to 4'b0000 during SHIFT has no effect.
REQ-034 WIDTH=8, load 8'hA5, assert rst after 3 bits -> outputs zero immediately; after release, load 8'h3C -> 0,0,1,1,1,1,0,0 with no residue of 8'hA5.
